// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative radix-2 MULT/MULTU/DIV/DIVU with HI/LO result regs
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;

  logic               w_sgn;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_div_step;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_sgn   = ~op_i[0];
  assign w_a_abs = (w_sgn && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_b_abs = (w_sgn && b_i[WIDTH-1]) ? -b_i : b_i;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign w_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign w_mul_step = {w_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left.
  assign w_rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, opnd_q};
  assign w_div_step = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  assign w_step = div_q ? w_div_step : w_mul_step;
  assign w_prod = neg_q  ? -w_step : w_step;
  assign w_quo  = neg_q  ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
  assign w_rem  = rneg_q ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      araw_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CALC;
          cnt_d   = '0;
          div_d   = op_i[1];
          neg_d   = w_sgn & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rneg_d  = w_sgn & op_i[1] & a_i[WIDTH-1];
          dz_d    = op_i[1] & (b_i == '0);
          araw_d  = a_i;
          opnd_d  = op_i[1] ? w_b_abs : w_a_abs;
          acc_d   = {{WIDTH{1'b0}}, (op_i[1] ? w_a_abs : w_b_abs)};
        end else begin
          if (hi_we_i) hi_d = a_i;
          if (lo_we_i) lo_d = a_i;
        end
      end
      S_CALC: begin
        acc_d = w_step;
        cnt_d = cnt_q + CW'(1);
        // Results land on the edge into FIN so done_o and HI/LO are seen together.
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = S_FIN;
          if (dz_q) begin
            hi_d = araw_q;
            lo_d = '1;
          end else if (div_q) begin
            hi_d = w_rem;
            lo_d = w_quo;
          end else begin
            hi_d = w_prod[2*WIDTH-1:WIDTH];
            lo_d = w_prod[WIDTH-1:0];
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_FIN);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

`default_nettype wire
